// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared response/state types and constants for the AXI4-Lite slave RAM
package axil_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    W_WAIT = 3'd1,
    W_RESP = 3'd2,
    R_WAIT = 3'd3,
    R_RESP = 3'd4
  } state_t;

endpackage

// File: rtl/axil_sp_ram.sv
// rtl/axil_sp_ram.sv - single-port word RAM, synchronous read, byte-enable write, no reset
module axil_sp_ram
  import axil_pkg::*;
#(
  parameter int DEPTH      = 1024,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       i_clk,
  input  logic                       i_we,
  input  logic [DATA_WIDTH/8-1:0]    i_be,
  input  logic                       i_re,
  input  logic [$clog2(DEPTH)-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]      i_wdata,
  output logic [DATA_WIDTH-1:0]      o_rdata
);

  localparam int BE_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Byte-lane writes and a registered read share the single address port
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (i_be[b]) begin
          r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axi4_lite_slave_ram.sv
// rtl/axi4_lite_slave_ram.sv - AXI4-Lite slave RAM with wait states and SLVERR decode; AXIL_SLAVE_WSTRB_EN enables byte strobes
module axi4_lite_slave_ram
  import axil_pkg::*;
#(
  parameter int                 ADDRESS    = 32,
  parameter int                 DATA_WIDTH = 32,
  parameter int                 DEPTH      = 1024,
  parameter logic [ADDRESS-1:0] BASE_ADDR  = '0,
  parameter int                 LATENCY    = 1
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ADDRESS-1:0]    S_AWADDR,
  input  logic                  S_AWVALID,
  output logic                  S_AWREADY,
  input  logic [DATA_WIDTH-1:0] S_WDATA,
  input  logic [3:0]            S_WSTRB,
  input  logic                  S_WVALID,
  output logic                  S_WREADY,
  output logic [1:0]            S_BRESP,
  output logic                  S_BVALID,
  input  logic                  S_BREADY,
  input  logic [ADDRESS-1:0]    S_ARADDR,
  input  logic                  S_ARVALID,
  output logic                  S_ARREADY,
  output logic [DATA_WIDTH-1:0] S_RDATA,
  output logic [1:0]            S_RRESP,
  output logic                  S_RVALID,
  input  logic                  S_RREADY
);

  localparam int                 IDX_W       = $clog2(DEPTH);
  localparam logic [ADDRESS:0]   P_BASE      = {1'b0, BASE_ADDR};
  localparam logic [ADDRESS:0]   P_LIMIT     = P_BASE + (ADDRESS+1)'(DEPTH * WORD_BYTES);
  localparam logic [3:0]         P_LAST_WAIT = 4'(LATENCY - 1);

  state_t r_state;
  state_t w_next_state;
  logic [3:0] r_wait_cnt;
  resp_t r_bresp;
  resp_t r_rresp;

  logic w_idle;
  logic w_wr_req;
  logic w_wr_hs;
  logic w_rd_hs;
  logic w_aw_in;
  logic w_ar_in;
  logic [ADDRESS-1:0] w_aw_off;
  logic [ADDRESS-1:0] w_ar_off;
  logic [IDX_W-1:0] w_ram_idx;
  logic [WORD_BYTES-1:0] w_be;
  logic w_ram_we;
  logic w_ram_re;
  logic [DATA_WIDTH-1:0] w_ram_rdata;
  logic w_unused_ok;

  // AW and W are only taken together; a pending write beats a read in the same cycle
  assign w_idle   = (r_state == IDLE);
  assign w_wr_req = S_AWVALID & S_WVALID;
  assign w_wr_hs  = w_idle & w_wr_req;
  assign w_rd_hs  = w_idle & S_ARVALID & ~w_wr_req;

  // Window decode is done one bit wider so BASE_ADDR + span cannot wrap
  assign w_aw_in  = ({1'b0, S_AWADDR} >= P_BASE) && ({1'b0, S_AWADDR} < P_LIMIT);
  assign w_ar_in  = ({1'b0, S_ARADDR} >= P_BASE) && ({1'b0, S_ARADDR} < P_LIMIT);
  assign w_aw_off = S_AWADDR - BASE_ADDR;
  assign w_ar_off = S_ARADDR - BASE_ADDR;

  assign w_ram_idx = w_wr_hs ? w_aw_off[2 +: IDX_W] : w_ar_off[2 +: IDX_W];
  assign w_ram_we  = w_wr_hs & w_aw_in & ~ARESET;
  assign w_ram_re  = w_rd_hs & w_ar_in & ~ARESET;

`ifdef AXIL_SLAVE_WSTRB_EN
  assign w_be        = S_WSTRB;
  assign w_unused_ok = &{1'b0, w_aw_off, w_ar_off};
`else
  assign w_be        = '1;
  assign w_unused_ok = &{1'b0, w_aw_off, w_ar_off, S_WSTRB};
`endif

  axil_sp_ram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .i_clk   (ACLK),
    .i_we    (w_ram_we),
    .i_be    (w_be),
    .i_re    (w_ram_re),
    .i_addr  (w_ram_idx),
    .i_wdata (S_WDATA),
    .o_rdata (w_ram_rdata)
  );

  // State register
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Wait-state counter and response codes captured at the request handshake
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wait_cnt <= '0;
      r_bresp    <= OKAY;
      r_rresp    <= OKAY;
    end else begin
      if (((r_state == W_WAIT) || (r_state == R_WAIT)) && (w_next_state == r_state)) begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
      end else begin
        r_wait_cnt <= '0;
      end
      if (w_wr_hs) begin
        r_bresp <= w_aw_in ? OKAY : SLVERR;
      end
      if (w_rd_hs) begin
        r_rresp <= w_ar_in ? OKAY : SLVERR;
      end
    end
  end

  // Next-state: one outstanding transaction, LATENCY wait cycles before the response
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_wr_hs) begin
          w_next_state = (LATENCY > 0) ? W_WAIT : W_RESP;
        end else if (w_rd_hs) begin
          w_next_state = (LATENCY > 0) ? R_WAIT : R_RESP;
        end
      end
      W_WAIT: if (r_wait_cnt == P_LAST_WAIT) w_next_state = W_RESP;
      R_WAIT: if (r_wait_cnt == P_LAST_WAIT) w_next_state = R_RESP;
      W_RESP: if (S_BREADY) w_next_state = IDLE;
      R_RESP: if (S_RREADY) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs decode from state; response fields read as zero whenever not presented
  always_comb begin
    S_AWREADY = w_wr_hs;
    S_WREADY  = w_wr_hs;
    S_ARREADY = w_rd_hs;
    S_BVALID  = (r_state == W_RESP);
    S_BRESP   = (r_state == W_RESP) ? r_bresp : OKAY;
    S_RVALID  = (r_state == R_RESP);
    S_RRESP   = (r_state == R_RESP) ? r_rresp : OKAY;
    S_RDATA   = ((r_state == R_RESP) && (r_rresp == OKAY)) ? w_ram_rdata : '0;
  end

endmodule

// File: tb/tb_axi4_lite_slave_ram.sv
// tb/tb_axi4_lite_slave_ram.sv - scoreboard bench for axi4_lite_slave_ram
module tb_axi4_lite_slave_ram;
  import axil_pkg::*;

  localparam int LAT    = 1;
  localparam int BUDGET = 40;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] S_AWADDR;
  logic        S_AWVALID;
  logic        S_AWREADY;
  logic [31:0] S_WDATA;
  logic [3:0]  S_WSTRB;
  logic        S_WVALID;
  logic        S_WREADY;
  logic [1:0]  S_BRESP;
  logic        S_BVALID;
  logic        S_BREADY;
  logic [31:0] S_ARADDR;
  logic        S_ARVALID;
  logic        S_ARREADY;
  logic [31:0] S_RDATA;
  logic [1:0]  S_RRESP;
  logic        S_RVALID;
  logic        S_RREADY;

  axi4_lite_slave_ram #(
    .ADDRESS    (32),
    .DATA_WIDTH (32),
    .DEPTH      (1024),
    .BASE_ADDR  (32'h0000_0000),
    .LATENCY    (LAT)
  ) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .S_AWADDR  (S_AWADDR),
    .S_AWVALID (S_AWVALID),
    .S_AWREADY (S_AWREADY),
    .S_WDATA   (S_WDATA),
    .S_WSTRB   (S_WSTRB),
    .S_WVALID  (S_WVALID),
    .S_WREADY  (S_WREADY),
    .S_BRESP   (S_BRESP),
    .S_BVALID  (S_BVALID),
    .S_BREADY  (S_BREADY),
    .S_ARADDR  (S_ARADDR),
    .S_ARVALID (S_ARVALID),
    .S_ARREADY (S_ARREADY),
    .S_RDATA   (S_RDATA),
    .S_RRESP   (S_RRESP),
    .S_RVALID  (S_RVALID),
    .S_RREADY  (S_RREADY)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    int          rise;
  } exp_t;

  exp_t bq[$];
  exp_t rq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: no response within %0d cycles (cycle %0d)", name, BUDGET, cyc);
  endtask

  task automatic wait_b_done(input string name);
    int n;
    n = 0;
    while (bq.size() != 0 && n <= BUDGET) begin
      @(posedge ACLK); #1;
      n++;
    end
    if (bq.size() != 0) begin
      timeout({name, "_b"});
      bq.delete();
    end
  endtask

  task automatic wait_r_done(input string name);
    int n;
    n = 0;
    while (rq.size() != 0 && n <= BUDGET) begin
      @(posedge ACLK); #1;
      n++;
    end
    if (rq.size() != 0) begin
      timeout({name, "_r"});
      rq.delete();
    end
  endtask

  // Called just after a rising edge; exp_wait is the number of cycles before AWREADY is expected
  task automatic do_write(input string name, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] er, input int exp_wait,
                          input bit wait_b);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    S_AWADDR = a; S_WDATA = d; S_WSTRB = s;
    S_AWVALID = 1'b1; S_WVALID = 1'b1;
    while (!seen && n <= BUDGET) begin
      @(negedge ACLK);
      if (S_AWREADY) seen = 1'b1; else n++;
    end
    if (!seen) begin
      timeout({name, "_aw"});
      @(posedge ACLK); #1;
      S_AWVALID = 1'b0; S_WVALID = 1'b0;
      return;
    end
    chk({name, "_aw_wait"}, 32'(n), 32'(exp_wait));
    chk({name, "_wready"}, 32'(S_WREADY), 32'd1);
    if (S_ARVALID) chk({name, "_arready_blocked"}, 32'(S_ARREADY), 32'd0);
    bq.push_back('{resp: er, data: 32'd0, rise: cyc + 1 + LAT});
    @(posedge ACLK); #1;
    S_AWVALID = 1'b0; S_WVALID = 1'b0;
    if (wait_b) wait_b_done(name);
  endtask

  task automatic do_read(input string name, input logic [31:0] a, input logic [31:0] ed,
                         input logic [1:0] er, input int exp_wait, input bit wait_r);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    S_ARADDR = a;
    S_ARVALID = 1'b1;
    while (!seen && n <= BUDGET) begin
      @(negedge ACLK);
      if (S_ARREADY) seen = 1'b1; else n++;
    end
    if (!seen) begin
      timeout({name, "_ar"});
      @(posedge ACLK); #1;
      S_ARVALID = 1'b0;
      return;
    end
    chk({name, "_ar_wait"}, 32'(n), 32'(exp_wait));
    rq.push_back('{resp: er, data: ed, rise: cyc + 1 + LAT});
    @(posedge ACLK); #1;
    S_ARVALID = 1'b0;
    if (wait_r) wait_r_done(name);
  endtask

  task automatic wait_valid(input string name, input bit is_b);
    int n;
    n = 0;
    while (n <= BUDGET) begin
      @(negedge ACLK);
      if (is_b ? S_BVALID : S_RVALID) break;
      n++;
    end
    if (n > BUDGET) timeout(name);
  endtask

  // Monitor: pops the scoreboard on every response handshake and checks stability while stalled
  logic        b_prev = 1'b0, r_prev = 1'b0;
  logic        b_hold = 1'b0, r_hold = 1'b0;
  logic        b_done = 1'b0, r_done = 1'b0;
  logic [1:0]  b_hold_resp, r_hold_resp;
  logic [31:0] r_hold_data;
  int          b_rise = -1, r_rise = -1;

  always @(negedge ACLK) begin
    exp_t e;
    if (b_hold) begin
      chk("b_stall_valid", 32'(S_BVALID), 32'd1);
      chk("b_stall_resp", 32'(S_BRESP), 32'(b_hold_resp));
    end
    if (r_hold) begin
      chk("r_stall_valid", 32'(S_RVALID), 32'd1);
      chk("r_stall_resp", 32'(S_RRESP), 32'(r_hold_resp));
      chk("r_stall_data", S_RDATA, r_hold_data);
    end
    if (b_done) chk("b_drop_after_hs", 32'(S_BVALID), 32'd0);
    if (r_done) begin
      chk("r_drop_after_hs", 32'(S_RVALID), 32'd0);
      chk("rdata_zero_after_hs", S_RDATA, 32'd0);
    end
    if (S_BVALID && !b_prev) b_rise = cyc;
    if (S_RVALID && !r_prev) r_rise = cyc;
    if (S_BVALID && S_BREADY) begin
      if (bq.size() == 0) begin
        timeout("b_unexpected");
      end else begin
        e = bq.pop_front();
        chk("bresp", 32'(S_BRESP), 32'(e.resp));
        chk("b_latency", 32'(b_rise), 32'(e.rise));
      end
    end
    if (S_RVALID && S_RREADY) begin
      if (rq.size() == 0) begin
        timeout("r_unexpected");
      end else begin
        e = rq.pop_front();
        chk("rresp", 32'(S_RRESP), 32'(e.resp));
        chk("rdata", S_RDATA, e.data);
        chk("r_latency", 32'(r_rise), 32'(e.rise));
      end
    end
    b_hold = S_BVALID && !S_BREADY;
    r_hold = S_RVALID && !S_RREADY;
    b_done = S_BVALID && S_BREADY;
    r_done = S_RVALID && S_RREADY;
    b_hold_resp = S_BRESP;
    r_hold_resp = S_RRESP;
    r_hold_data = S_RDATA;
    b_prev = S_BVALID;
    r_prev = S_RVALID;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    ARESET = 1'b1;
    S_AWADDR = '0; S_AWVALID = 1'b0; S_WDATA = '0; S_WSTRB = 4'hF; S_WVALID = 1'b0;
    S_BREADY = 1'b1; S_ARADDR = '0; S_ARVALID = 1'b0; S_RREADY = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    @(negedge ACLK);
    chk("rst_bvalid", 32'(S_BVALID), 32'd0);
    chk("rst_rvalid", 32'(S_RVALID), 32'd0);
    chk("rst_bresp", 32'(S_BRESP), 32'd0);
    chk("rst_rresp", 32'(S_RRESP), 32'd0);
    chk("rst_rdata", S_RDATA, 32'd0);
    chk("rst_awready", 32'(S_AWREADY), 32'd0);
    chk("rst_arready", 32'(S_ARREADY), 32'd0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;

    // Basic write/read, out-of-range, boundaries, misaligned
    do_write("wr10", 32'h10, 32'hDEADBEEF, 4'hF, 2'b00, 0, 1'b1);
    do_read ("rd10", 32'h10, 32'hDEADBEEF, 2'b00, 0, 1'b1);
    do_write("wr0", 32'h0, 32'hCAFEF00D, 4'hF, 2'b00, 0, 1'b1);
    do_write("wr_oor", 32'h1000, 32'hFFFFFFFF, 4'hF, 2'b10, 0, 1'b1);
    do_read ("rd_oor", 32'h1000, 32'h0, 2'b10, 0, 1'b1);
    do_read ("rd0_kept", 32'h0, 32'hCAFEF00D, 2'b00, 0, 1'b1);
    do_write("wr_last", 32'hFFC, 32'h5A5A0FF0, 4'hF, 2'b00, 0, 1'b1);
    do_read ("rd_last", 32'hFFC, 32'h5A5A0FF0, 2'b00, 0, 1'b1);
    do_read ("rd_misaligned", 32'h13, 32'hDEADBEEF, 2'b00, 0, 1'b1);

    // B backpressure, then a read accepted in the first IDLE cycle
    S_BREADY = 1'b0;
    do_write("wr_bp", 32'h20, 32'h0BADF00D, 4'hF, 2'b00, 0, 1'b0);
    wait_valid("bp_bvalid", 1'b1);
    repeat (5) @(posedge ACLK);
    #1;
    S_BREADY = 1'b1;
    @(posedge ACLK); #1;
    chk("bp_b_popped", 32'(bq.size()), 32'd0);
    do_read("rd_after_bbp", 32'h20, 32'h0BADF00D, 2'b00, 0, 1'b1);

    // R backpressure, then a write accepted in the first IDLE cycle
    S_RREADY = 1'b0;
    do_read("rd_bp", 32'h10, 32'hDEADBEEF, 2'b00, 0, 1'b0);
    wait_valid("bp_rvalid", 1'b0);
    repeat (5) @(posedge ACLK);
    #1;
    S_RREADY = 1'b1;
    @(posedge ACLK); #1;
    chk("bp_r_popped", 32'(rq.size()), 32'd0);
    do_write("wr_after_rbp", 32'h24, 32'h01020304, 4'hF, 2'b00, 0, 1'b1);

    // Simultaneous AW+W+AR: write first, read right after the B handshake
    S_ARADDR = 32'h24;
    S_ARVALID = 1'b1;
    do_write("wr_sim", 32'h28, 32'h13579BDF, 4'hF, 2'b00, 0, 1'b0);
    do_read ("rd_sim", 32'h24, 32'h01020304, 2'b00, LAT + 1, 1'b1);
    wait_b_done("sim");
    do_read ("rd_sim_wr", 32'h28, 32'h13579BDF, 2'b00, 0, 1'b1);

    // Lone AWVALID, then lone WVALID, are never acknowledged
    S_AWADDR = 32'h2C;
    S_AWVALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      chk("lone_aw_awready", 32'(S_AWREADY), 32'd0);
      chk("lone_aw_wready", 32'(S_WREADY), 32'd0);
    end
    @(posedge ACLK); #1;
    do_write("wr_lone", 32'h2C, 32'h2468ACE0, 4'hF, 2'b00, 0, 1'b1);
    S_WVALID = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge ACLK);
      chk("lone_w_wready", 32'(S_WREADY), 32'd0);
    end
    @(posedge ACLK); #1;
    S_WVALID = 1'b0;
    do_read("rd_lone", 32'h2C, 32'h2468ACE0, 2'b00, 0, 1'b1);

    // Reset during R_WAIT drops the response
    do_read("rd_rst", 32'h10, 32'hDEADBEEF, 2'b00, 0, 1'b0);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    @(negedge ACLK);
    chk("rst_rwait_rvalid", 32'(S_RVALID), 32'd0);
    chk("rst_rwait_rdata", S_RDATA, 32'd0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    rq.delete();
    do_read("rd_after_rst", 32'h2C, 32'h2468ACE0, 2'b00, 0, 1'b1);

    // Reset during W_WAIT: the committed write survives
    do_write("wr_rst", 32'h30, 32'h0F0F0F0F, 4'hF, 2'b00, 0, 1'b0);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    @(negedge ACLK);
    chk("rst_wwait_bvalid", 32'(S_BVALID), 32'd0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    bq.delete();
    do_read("rd_committed", 32'h30, 32'h0F0F0F0F, 2'b00, 0, 1'b1);

    // Byte strobes
    do_write("wr_strb_base", 32'h40, 32'h11223344, 4'hF, 2'b00, 0, 1'b1);
    do_write("wr_strb", 32'h40, 32'hAABBCCDD, 4'b0011, 2'b00, 0, 1'b1);
`ifdef AXIL_SLAVE_WSTRB_EN
    do_read ("rd_strb", 32'h40, 32'h1122CCDD, 2'b00, 0, 1'b1);
    do_write("wr_strb0", 32'h40, 32'hFFFFFFFF, 4'b0000, 2'b00, 0, 1'b1);
    do_read ("rd_strb0", 32'h40, 32'h1122CCDD, 2'b00, 0, 1'b1);
`else
    do_read ("rd_strb", 32'h40, 32'hAABBCCDD, 2'b00, 0, 1'b1);
`endif

    repeat (3) @(posedge ACLK);
    #1;
    chk("end_bq_empty", 32'(bq.size()), 32'd0);
    chk("end_rq_empty", 32'(rq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4_lite_slave_ram.md
Name: axi4_lite_slave_ram

Overview:
- AXI4-Lite slave that terminates the CPU's AXI4-Lite master port with a word-addressed, single-port RAM.
- Sits directly downstream of the master and consumes its AW/W/AR transactions.
- Returns B and R responses after a configurable wait-state latency.
- Flags out-of-range addresses with SLVERR.

Parameters:
- ADDRESS, 32, address width in bits.
- DATA_WIDTH, 32, data width in bits; fixed to 32.
- DEPTH, 1024, number of RAM words; must be a power of 2.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- LATENCY, 1, extra wait cycles between request acceptance and response valid (0..15).

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  synchronous, active-high reset.
- S_AWADDR  in  ADDRESS  write address.
- S_AWVALID  in  1  write address valid.
- S_AWREADY  out  1  write address ready.
- S_WDATA  in  DATA_WIDTH  write data.
- S_WSTRB  in  4  byte strobes; only used when the optional feature is compiled in.
- S_WVALID  in  1  write data valid.
- S_WREADY  out  1  write data ready.
- S_BRESP  out  2  write response.
- S_BVALID  out  1  write response valid.
- S_BREADY  in  1  write response ready.
- S_ARADDR  in  ADDRESS  read address.
- S_ARVALID  in  1  read address valid.
- S_ARREADY  out  1  read address ready.
- S_RDATA  out  DATA_WIDTH  read data.
- S_RRESP  out  2  read response.
- S_RVALID  out  1  read data valid.
- S_RREADY  in  1  read data ready.

Behaviour:
- Reset:
  - One clock, ACLK. Reset ARESET is synchronous and active-high.
  - While ARESET=1 at a rising edge: state=IDLE, wait counter=0, and S_BVALID, S_RVALID, S_BRESP, S_RRESP, S_RDATA all 0.
  - S_AWREADY, S_WREADY and S_ARREADY are 0 because they decode from IDLE with the valids low.
  - RAM contents are not reset.
- Reset mid-transaction: the pending response is dropped. A write already committed at its handshake edge stays in RAM.
- States: IDLE, W_WAIT, W_RESP, R_WAIT, R_RESP.
- Write acceptance:
  - S_AWREADY = S_WREADY = (state==IDLE) & S_AWVALID & S_WVALID, combinational.
  - AW and W are accepted only together, in the same cycle. A lone AWVALID or lone WVALID is never acknowledged.
- Read acceptance: S_ARREADY = (state==IDLE) & S_ARVALID & ~(S_AWVALID & S_WVALID). A simultaneous write wins; the read waits.
- Address decode:
  - in_range = (addr >= BASE_ADDR) & (addr < BASE_ADDR + DEPTH*4).
  - Word index = (addr - BASE_ADDR)[2 +: log2(DEPTH)].
  - addr[1:0] is ignored; a misaligned address is not an error.
- Write handshake edge:
  - If in_range, the RAM word is written at that edge.
  - Response code latched: OKAY=2'b00 if in range, SLVERR=2'b10 if out of range (no RAM write).
  - Next state is W_WAIT when LATENCY>0, else W_RESP.
- Read handshake edge:
  - The RAM word is read (synchronous read). Out of range yields data 0 and SLVERR.
  - Next state is R_WAIT or R_RESP, by the same LATENCY rule.
- W_WAIT / R_WAIT: count LATENCY cycles, then go to *_RESP.
- Response timing: S_BVALID / S_RVALID rise exactly LATENCY+1 cycles after the handshake edge.
- W_RESP:
  - S_BVALID=1 with the latched S_BRESP.
  - Held stable until S_BREADY=1.
  - On the BVALID&BREADY edge: go to IDLE; BVALID drops the next cycle.
- R_RESP:
  - S_RVALID=1, with S_RDATA and S_RRESP held stable until S_RREADY.
  - On the RVALID&RREADY edge: go to IDLE; S_RDATA returns to 0.
- Outstanding transactions: exactly one at a time. No ready is asserted outside IDLE.
- Back-to-back: a new request can be accepted in the first IDLE cycle, i.e. the cycle after the response handshake.

Optional Feature:
- Macro: AXIL_SLAVE_WSTRB_EN.
- Defined: the write updates only the bytes whose S_WSTRB bit is 1. WSTRB=4'b0000 writes nothing but still returns OKAY if in range.
- Undefined: S_WSTRB is ignored and all four bytes are written. This matches masters that do not drive strobes.

Decomposition:
- Package axil_pkg holds:
  - resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - slave state_t enum.
  - localparam WORD_BYTES=4.
- Sub-module axil_sp_ram holds the RAM:
  - single port, synchronous read, byte-enable write.
  - parameters DEPTH and DATA_WIDTH.
  - The slave FSM and decode stay in the top.

Test Plan:
- Write then read, LATENCY=1:
  - AW=0x10, W=0xDEADBEEF, both valid -> AWREADY=WREADY=1 same cycle; BVALID 2 cycles later with BRESP=0.
  - Then AR=0x10 -> RVALID 2 cycles after the AR handshake with RDATA=0xDEADBEEF, RRESP=0.
- Out of range, DEPTH=1024:
  - Write to 0x1000 -> BRESP=2'b10 and the RAM is unchanged.
  - Read from 0x1000 -> RDATA=0, RRESP=2'b10.
- Backpressure: hold BREADY=0 for 5 cycles -> BVALID and BRESP stay stable; FSM is in IDLE the cycle after BREADY=1. Repeat for R with RREADY.
- Simultaneous AW+W+AR -> write accepted first and ARREADY=0; the read is accepted the first IDLE cycle after the B handshake.
- Lone AWVALID for 3 cycles with WVALID=0 -> AWREADY stays 0; raising WVALID -> both readies 1 the same cycle.
- Reset during R_WAIT -> RVALID=0 and state IDLE. With AXIL_SLAVE_WSTRB_EN and WSTRB=4'b0011 writing 0xAABBCCDD over 0x11223344 -> a read returns 0x1122CCDD.
